icache: RTL
===========

ICACHE -- requirements
Module: icache

Interface
REQ-001: Parameter NFRAMES, default 16, number of direct-mapped frames (power of two, 2..64); one 32-bit word per frame.
REQ-002: CLK  input  1  rising-edge clock; the block has one clock.
REQ-003: nRST  input  1  reset, synchronous, active-low.
REQ-004: imemREN  input  1  datapath instruction read request.
REQ-005: imemaddr  input  32  datapath instruction byte address; bits [1:0] ignored.
REQ-006: flush  input  1  invalidate all frames.
REQ-007: ihit  output  1  imemload valid for current imemaddr this cycle.
REQ-008: imemload  output  32  instruction word returned to datapath.
REQ-009: iREN  output  1  read request to memory controller.
REQ-010: iaddr  output  32  word-aligned address to memory controller.
REQ-011: iwait  input  1  memory busy; iload valid in a cycle where iREN=1 and iwait=0.
REQ-012: iload  input  32  instruction word from memory controller.

Function
REQ-013: Address split: offset = imemaddr[1:0]; index = imemaddr[2+IW-1:2], IW = log2(NFRAMES); tag = imemaddr[31:2+IW].
REQ-014: Per-frame storage: valid bit, tag, 32-bit data word.
REQ-015: Two states, IDLE and FETCH; hit path combinational, all storage/state updated on CLK rising edge only.
REQ-016: IDLE: ihit = imemREN & valid[index] & tag match, same cycle (zero-cycle hit latency); imemload = frame data when ihit, else 0.
REQ-017: IDLE with imemREN=1 and miss -> latch {imemaddr[31:2],2'b00} into miss_addr, go to FETCH next cycle.
REQ-018: IDLE with imemREN=0 -> ihit=0, iREN=0, stay IDLE.
REQ-019: FETCH: iREN=1, iaddr=miss_addr (stable for entire FETCH regardless of imemaddr), ihit=0.
REQ-020: FETCH with iwait=1 -> stay FETCH, no storage change.
REQ-021: FETCH with iwait=0 -> write iload, tag, valid=1 into frame indexed by miss_addr; go IDLE; ihit not asserted in the fill cycle.
REQ-022: Miss latency: miss-detect cycle + FETCH cycles (>=1) + ihit in following IDLE cycle if imemaddr unchanged; minimum 3 cycles from first request to ihit.
REQ-023: imemREN deasserted or imemaddr changed during FETCH: fill completes to miss_addr anyway; IDLE then re-evaluates current imemaddr.
REQ-024: Miss to a frame holding a different valid tag: fill overwrites (evicts) it.
REQ-025: flush=1 in any state: next edge clears all valid bits, state -> IDLE, pending fill discarded (no write even if iwait=0 that cycle); ihit=0 and iREN=0 while flush=1.
REQ-026: iREN=0 and iaddr=0 whenever state is IDLE.
REQ-027: Outputs ihit, imemload, iREN, iaddr are functions of state, storage and current inputs only; no combinational path iload -> ihit.

Reset
REQ-028: nRST sampled low at a CLK edge: state -> IDLE, all valid bits 0, miss_addr 0; tag/data need not be cleared.
REQ-029: After reset edge: ihit=0, imemload=0, iREN=0, iaddr=0 until a request arrives.
REQ-030: nRST low during FETCH aborts the fill; no frame written in that cycle; nRST takes priority over flush.

Verification
REQ-031: Cold miss: reset, imemREN=1, imemaddr=0x00000040, iwait=1 two cycles then 0 with iload=0x8C220004 -> iREN=1, iaddr=0x00000040 for 3 cycles, ihit=1 with imemload=0x8C220004 on the next cycle.
REQ-032: Hit after fill: same address requested again -> ihit=1 same cycle, iREN stays 0.
REQ-033: Conflict eviction (NFRAMES=16): fill 0x00000040, then request 0x00000080... request 0x00000440 (same index 0, different tag) -> miss, fetch, 0x00000040 subsequently misses.
REQ-034: Address change mid-fetch: miss on 0x00000100, change imemaddr to 0x00000200 during FETCH -> iaddr stays 0x00000100; frame for 0x100 filled; then 0x200 misses and fetches.
REQ-035: Flush: frames valid, assert flush during FETCH with iwait=0 -> no write, state IDLE; previously valid 0x00000040 now misses.
REQ-036: Sync reset mid-fetch: nRST=0 for one edge during FETCH -> iREN=0 next cycle, all frames invalid, next request misses.

Source files
------------

// File: rtl/icache.sv
// Direct-mapped instruction cache, one 32-bit word per frame.
// Hits return in the same cycle; misses stall in FETCH until the memory controller drops iwait.
module icache #(
  parameter int NFRAMES = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        flush,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  localparam int IW = $clog2(NFRAMES);
  localparam int TW = 30 - IW;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [29:0]        miss_addr_q, miss_addr_d;
  logic [NFRAMES-1:0] valid_q;
  logic [TW-1:0]      tag_q  [NFRAMES];
  logic [31:0]        data_q [NFRAMES];

  logic [IW-1:0] req_idx;
  logic [TW-1:0] req_tag;
  logic [IW-1:0] fill_idx;
  logic [TW-1:0] fill_tag;
  logic          lookup_hit;
  logic          fill_we;
  logic          unused_offset;

  assign req_idx       = imemaddr[2+IW-1:2];
  assign req_tag       = imemaddr[31:2+IW];
  assign fill_idx      = miss_addr_q[IW-1:0];
  assign fill_tag      = miss_addr_q[29:IW];
  assign lookup_hit    = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign unused_offset = ^imemaddr[1:0];

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    ihit        = 1'b0;
    imemload    = 32'h0;
    iREN        = 1'b0;
    iaddr       = 32'h0;
    fill_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (imemREN && !flush) begin
          if (lookup_hit) begin
            ihit     = 1'b1;
            imemload = data_q[req_idx];
          end else begin
            state_d     = FETCH;
            miss_addr_d = imemaddr[31:2];
          end
        end
      end
      FETCH: begin
        // The miss address is held for the whole fetch, whatever the datapath does meanwhile.
        iaddr = {miss_addr_q, 2'b00};
        iREN  = !flush;
        if (!iwait) begin
          fill_we = !flush;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
    end
  end

  for (genvar gi = 0; gi < NFRAMES; gi++) begin : g_valid
    always_ff @(posedge CLK) begin
      if (!nRST || flush) begin
        valid_q[gi] <= 1'b0;
      end else if (fill_we && (fill_idx == IW'(gi))) begin
        valid_q[gi] <= 1'b1;
      end
    end
  end

  // Tag and data are qualified by valid_q, so they carry no reset.
  always_ff @(posedge CLK) begin
    if (nRST && fill_we) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= iload;
    end
  end

endmodule
